ifu: RTL

Instruction fetch unit for the single-issue RV64 core. It sits directly upstream of the decode/control stage. It owns the fetch PC and issues in-order requests to instruction memory over a valid/ready handshake. Returned words are buffered in a small FIFO and presented to decode as (inst, inst_pc) with valid/ready. It also handles branch/jump redirects and the ebreak halt.

---
 rtl/ifu_if.sv | 32 +++
 rtl/ifu.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ifu_if.sv
// Handshake bundle shared by the fetch unit, instruction memory and decode.
// The master modport is the fetch unit's view; slave is the environment's view.
interface ifu_if #(
  parameter int CPU_WIDTH  = 32,
  parameter int ADDR_WIDTH = 64
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [CPU_WIDTH-1:0]  imem_rsp_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [CPU_WIDTH-1:0]  inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt_req;
  logic                  halted;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, halted,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, halted,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc, halt_req
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited memory requests
// and buffers returned words with their PCs for decode; handles redirects and halt.
module ifu #(
  parameter int                    CPU_WIDTH  = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  ifu_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [CW-1:0]         out_cnt_q, drop_cnt_q, fifo_cnt_q;
  logic [PW-1:0]         fifo_rd_q, fifo_wr_q, pcq_rd_q, pcq_wr_q;
  logic [CPU_WIDTH-1:0]  fifo_inst_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_q       [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic [CW-1:0] out_cnt_d;
  logic          req_valid, accept, rsp, pop, push;
  logic          halt_go, redirect_go, flush;

  // A request is only issued when its response is guaranteed a FIFO slot.
  assign credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
  assign req_valid   = (state_q == RUN) && !bus.redirect_valid && !bus.halt_req &&
                       (credit_used < DEPTH_W);
  assign accept      = req_valid && bus.imem_req_ready;
  assign rsp         = bus.imem_rsp_valid;
  assign pop         = (fifo_cnt_q != '0) && bus.inst_ready;
  assign halt_go     = bus.halt_req && (state_q != HALT);
  assign redirect_go = bus.redirect_valid && (state_q == RUN) && !bus.halt_req;
  assign flush       = halt_go || redirect_go;
  assign push        = rsp && (drop_cnt_q == '0) && (state_q == RUN) && !flush;
  assign out_cnt_d   = out_cnt_q + CW'(accept) - CW'(rsp);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.inst_valid     = (fifo_cnt_q != '0);
  assign bus.inst           = fifo_inst_q[fifo_rd_q];
  assign bus.inst_pc        = fifo_pc_q[fifo_rd_q];
  assign bus.halted         = (state_q == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      case (state_q)
        BOOT:    state_q <= bus.halt_req ? HALT : RUN;
        RUN:     if (bus.halt_req) state_q <= HALT;
        default: state_q <= HALT;
      endcase

      out_cnt_q <= out_cnt_d;

      if (redirect_go) begin
        fetch_pc_q <= bus.redirect_pc & ~ADDR_WIDTH'(3);
      end else if (accept) begin
        fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
      end

      // Side queue pairs each in-order response with the address it was fetched from.
      if (accept) begin
        pcq_q[pcq_wr_q] <= fetch_pc_q;
        pcq_wr_q        <= pcq_wr_q + PW'(1);
      end
      if (rsp) begin
        pcq_rd_q <= pcq_rd_q + PW'(1);
      end

      if (push) begin
        fifo_inst_q[fifo_wr_q] <= bus.imem_rsp_data;
        fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
        fifo_wr_q              <= fifo_wr_q + PW'(1);
      end

      // Everything still in flight at a flush belongs to the abandoned path.
      if (flush) begin
        fifo_cnt_q <= '0;
        fifo_rd_q  <= fifo_wr_q;
        drop_cnt_q <= out_cnt_d;
      end else begin
        if (pop) begin
          fifo_rd_q <= fifo_rd_q + PW'(1);
        end
        fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
        if (rsp && (drop_cnt_q != '0)) begin
          drop_cnt_q <= drop_cnt_q - CW'(1);
        end
      end
    end
  end

  a_counters_in_range: assert property (@(posedge clk) disable iff (rst)
    (out_cnt_q <= DEPTH_C) && (fifo_cnt_q <= DEPTH_C) &&
    (drop_cnt_q <= out_cnt_q) && (credit_used <= DEPTH_W));

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (out_cnt_q != '0));
endmodule
